// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one CPU request at a time, performs
// word or byte loads/stores against a 16-bit-wide data memory (byte stores
// use read-modify-write), and returns a response held until accepted.
module lsu_ctrl #(
   parameter int DEPTH = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_byte,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic [15:0] mem_addr,
   output logic        mem_we,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   state_t      state;
   state_t      state_next;

   logic        lat_we;
   logic        lat_byte;
   logic        lat_lo;
   logic [14:0] lat_idx;
   logic [15:0] lat_wdata;
   logic [15:0] rdata_q;
   logic        err_q;

   logic        accept;
   logic        req_err;
   logic [15:0] sel_byte;
   logic [15:0] merged;

   // A request is taken only while idle; it is rejected when the word index
   // is outside the memory or a word access is not halfword aligned.
   assign accept   = req_valid && (state == IDLE);
   assign req_err  = ({1'b0, req_addr[15:1]} >= DEPTH_W) || (!req_byte && req_addr[0]);

   // Little-endian byte select for loads and byte merge for byte stores.
   assign sel_byte = lat_lo ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]};
   assign merged   = lat_lo ? {lat_wdata[7:0], mem_rdata[7:0]}
                            : {mem_rdata[15:8], lat_wdata[7:0]};

   // State register; an asserted reset returns to IDLE immediately, which
   // also drops mem_we at once because all outputs decode from the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request latch at acceptance, then load-data capture or merged-word
   // capture on the edge that leaves RD.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_we    <= 1'b0;
         lat_byte  <= 1'b0;
         lat_lo    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else if (accept) begin
         lat_we    <= req_we;
         lat_byte  <= req_byte;
         lat_lo    <= req_addr[0];
         lat_idx   <= req_addr[15:1];
         lat_wdata <= req_wdata;
         rdata_q   <= '0;
         err_q     <= req_err;
      end else if (state == RD) begin
         if (lat_we) begin
            lat_wdata <= merged;
         end else begin
            rdata_q <= lat_byte ? sel_byte : mem_rdata;
         end
      end
   end

   // Next-state selection and Moore-style output decode.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err) begin
                  state_next = RESP;
               end else if (!req_we || req_byte) begin
                  state_next = RD;
               end else begin
                  state_next = WR;
               end
            end
         end
         RD: begin
            mem_addr   = {1'b0, lat_idx};
            state_next = lat_we ? WR : RESP;
         end
         WR: begin
            mem_addr   = {1'b0, lat_idx};
            mem_we     = 1'b1;
            mem_wdata  = lat_wdata;
            state_next = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
            resp_err   = err_q;
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The module SHALL have a parameter line: DEPTH, 128, number of 16-bit words in the attached data memory.
REQ-002 The module SHALL have a port line: clk  input  1  clock; all state updates on rising edge.
REQ-003 The module SHALL have a port line: reset  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have a port line: req_valid  input  1  CPU request present.
REQ-005 The module SHALL have a port line: req_ready  output  1  unit can accept a request.
REQ-006 The module SHALL have a port line: req_we  input  1  1 = store, 0 = load.
REQ-007 The module SHALL have a port line: req_byte  input  1  1 = byte access, 0 = word access.
REQ-008 The module SHALL have a port line: req_addr  input  16  byte address; word index = req_addr[15:1].
REQ-009 The module SHALL have a port line: req_wdata  input  16  store data; byte stores use bits [7:0].
REQ-010 The module SHALL have a port line: resp_valid  output  1  response present.
REQ-011 The module SHALL have a port line: resp_ready  input  1  CPU accepts response.
REQ-012 The module SHALL have a port line: resp_rdata  output  16  load data; 0 for stores and errors.
REQ-013 The module SHALL have a port line: resp_err  output  1  request rejected, no memory write.
REQ-014 The module SHALL have a port line: mem_addr  output  16  word index to data memory.
REQ-015 The module SHALL have a port line: mem_we  output  1  memory write enable; memory commits on falling clk edge.
REQ-016 The module SHALL have a port line: mem_wdata  output  16  memory write data.
REQ-017 The module SHALL have a port line: mem_rdata  input  16  combinational memory read of mem_addr.

Function
REQ-018 The FSM SHALL have states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-019 Acceptance SHALL be req_valid & req_ready at a rising edge; req_we, req_byte, req_addr, and req_wdata SHALL be latched at that edge.
REQ-020 An error SHALL be flagged when req_addr[15:1] >= DEPTH, or when the access is a word access with req_addr[0] = 1.
REQ-021 IDLE transitions SHALL be: error -> RESP with resp_err = 1; load -> RD; word store -> WR; byte store -> RD.
REQ-022 In RD: mem_addr = latched word index, mem_we = 0, and mem_rdata SHALL be captured at the exiting edge.
REQ-023 A load SHALL go RD -> RESP.
REQ-024 A byte load SHALL return zero-extended byte addr[0]=0 -> mem_rdata[7:0], addr[0]=1 -> mem_rdata[15:8] (little-endian).
REQ-025 A byte store SHALL go RD -> WR with merged word: the selected byte is replaced by req_wdata[7:0] and the other byte keeps the captured value.
REQ-026 In WR: mem_we = 1 for exactly one cycle, mem_addr = latched index, mem_wdata = word store data or merged word; then -> RESP.
REQ-027 mem_we SHALL be 0 in every state except WR; mem_addr SHALL be held at the latched index in RD and WR, and at 0 in IDLE.
REQ-028 In RESP: resp_valid = 1, and resp_rdata/resp_err SHALL be stable until resp_valid & resp_ready, then -> IDLE.
REQ-029 A new request SHALL be acceptable no earlier than the cycle after the response handshake.
REQ-030 Latency from acceptance edge to resp_valid SHALL be: error 1 cycle; load 2; word store 2; byte store 3.
REQ-031 Outside RESP, resp_valid, resp_err, and resp_rdata SHALL be 0.

Reset
REQ-032 When reset = 0, the FSM SHALL go to IDLE immediately and all latched registers SHALL be cleared to 0.
REQ-033 When reset = 0: req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_we = 0, mem_addr = 0, and mem_wdata = 0.
REQ-034 When reset is asserted during WR, mem_we SHALL drop asynchronously and no partial or merged write SHALL be required to complete.

Verification
REQ-035 Bench SHALL cover: word store addr 0x0010 data 0xBEEF, then word load 0x0010 -> resp_rdata = 0xBEEF, resp_err = 0, with store and load latency 2 cycles each.
REQ-036 Bench SHALL cover: mem[8] = 0x1234, byte store addr 0x0011 data 0x00AB -> mem[8] = 0xAB34, latency 3; byte load 0x0011 -> 0x00AB; byte load 0x0010 -> 0x0034.
REQ-037 Bench SHALL cover: word load addr 0x0003 -> resp_err = 1 after 1 cycle, mem_we never asserted; word store addr 0x0100 (index 128) -> resp_err = 1, memory unchanged.
REQ-038 Bench SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid and data stable, req_ready = 0, and a second req_valid is ignored until the handshake.
REQ-039 Bench SHALL cover: reset pulled low in WR of a word store -> mem_we = 0 immediately, outputs at reset values, and the next request is accepted normally after release.
REQ-040 Bench SHALL cover: back-to-back requests with req_valid held high -> each accepted exactly once, in IDLE only, responses in order.
